// File: rtl/stream_demux.sv
// stream_demux: one-to-NCH valid/ready demultiplexer with a one-entry register per channel.
// Optional round-robin destination selection is enabled by defining STREAM_DEMUX_RR_EN.
module stream_demux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef STREAM_DEMUX_RR_EN
  input  logic                  rr_mode,
`endif
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  input  logic [SELW-1:0]       s_sel,
  output logic [NCH-1:0]        m_valid,
  input  logic [NCH-1:0]        m_ready,
  output logic [NCH*WIDTH-1:0]  m_data,
  output logic                  err,
  input  logic                  err_clr,
  output logic [NCH*16-1:0]     beat_cnt
);

  logic [SELW-1:0]  dest;
  logic             in_range;
  logic             dest_free;
  logic             accept;
  logic [NCH-1:0]   load;

  logic [NCH-1:0]   valid_q, valid_d;
  logic [WIDTH-1:0] data_q [NCH];
  logic [WIDTH-1:0] data_d [NCH];
  logic [15:0]      cnt_q  [NCH];
  logic [15:0]      cnt_d  [NCH];
  logic             err_q, err_d;

`ifdef STREAM_DEMUX_RR_EN
  logic [SELW-1:0]  ptr_q, ptr_d;

  assign dest = rr_mode ? ptr_q : s_sel;
`else
  assign dest = s_sel;
`endif

  // Out-of-range destinations always look free so the beat is consumed and dropped.
  always_comb begin
    in_range  = 1'b0;
    dest_free = 1'b1;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (dest == SELW'(k)) begin
        in_range  = 1'b1;
        dest_free = ~valid_q[k] | m_ready[k];
      end
    end
  end

  assign s_ready = dest_free;
  assign accept  = s_valid & s_ready;

  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      load[k] = accept & in_range & (dest == SELW'(k));
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      valid_d[k] = load[k] | (valid_q[k] & ~m_ready[k]);
      data_d[k]  = load[k] ? s_data : data_q[k];
      cnt_d[k]   = (load[k] && cnt_q[k] != 16'hFFFF) ? cnt_q[k] + 16'd1 : cnt_q[k];
    end
  end

  // A dropped beat in the same cycle as err_clr keeps the flag set.
  assign err_d = (accept & ~in_range) | (err_q & ~err_clr);

`ifdef STREAM_DEMUX_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (rr_mode && accept) begin
      ptr_d = (ptr_q == SELW'(NCH - 1)) ? '0 : ptr_q + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int unsigned k = 0; k < NCH; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  always_comb begin
    m_data   = '0;
    beat_cnt = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      m_data[k*WIDTH +: WIDTH] = data_q[k];
      beat_cnt[k*16 +: 16]     = cnt_q[k];
    end
  end

  assign m_valid = valid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux: a 4-channel and a 3-channel instance.
module tb_stream_demux;

  logic        clk;
  logic        rst_n;

  logic        s_valid4, s_ready4, err4, err_clr4;
  logic [7:0]  s_data4;
  logic [1:0]  s_sel4;
  logic [3:0]  m_valid4, m_ready4;
  logic [31:0] m_data4;
  logic [63:0] beat_cnt4;

  logic        s_valid3, s_ready3, err3, err_clr3;
  logic [7:0]  s_data3;
  logic [1:0]  s_sel3;
  logic [2:0]  m_valid3, m_ready3;
  logic [23:0] m_data3;
  logic [47:0] beat_cnt3;

`ifdef STREAM_DEMUX_RR_EN
  logic        rr_mode4, rr_mode3;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  stream_demux #(.WIDTH(8), .NCH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
`ifdef STREAM_DEMUX_RR_EN
    .rr_mode(rr_mode4),
`endif
    .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4), .s_sel(s_sel4),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4),
    .err(err4), .err_clr(err_clr4), .beat_cnt(beat_cnt4)
  );

  stream_demux #(.WIDTH(8), .NCH(3)) u3 (
    .clk(clk), .rst_n(rst_n),
`ifdef STREAM_DEMUX_RR_EN
    .rr_mode(rr_mode3),
`endif
    .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3), .s_sel(s_sel3),
    .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3),
    .err(err3), .err_clr(err_clr3), .beat_cnt(beat_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if (m_valid4 !== 4'b0000) $display("FAIL reset_m_valid: got %b expected %b", m_valid4, 4'b0000);
    else pass_cnt++;
    total_cnt++;
    if (m_data4 !== 32'h0) $display("FAIL reset_m_data: got %h expected %h", m_data4, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (err4 !== 1'b0) $display("FAIL reset_err: got %b expected %b", err4, 1'b0);
    else pass_cnt++;
    total_cnt++;
    if (beat_cnt4 !== 64'h0) $display("FAIL reset_beat_cnt: got %h expected %h", beat_cnt4, 64'h0);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (s_ready4 !== 1'b1) $display("FAIL idle_s_ready: got %b expected %b", s_ready4, 1'b1);
    else pass_cnt++;
    total_cnt++;
    if (m_valid4 !== 4'b0000) $display("FAIL idle_m_valid: got %b expected %b", m_valid4, 4'b0000);
    else pass_cnt++;
  endtask

  task automatic test_routing();
    m_ready4 = 4'b1111;
    s_valid4 = 1'b1;
    s_sel4   = 2'd2;
    s_data4  = 8'hA5;
    tick();
    s_valid4 = 1'b0;
    #1;
    total_cnt++;
    if (m_valid4 !== 4'b0100) $display("FAIL route_m_valid: got %b expected %b", m_valid4, 4'b0100);
    else pass_cnt++;
    total_cnt++;
    if (m_data4[23:16] !== 8'hA5) $display("FAIL route_data: got %h expected %h", m_data4[23:16], 8'hA5);
    else pass_cnt++;
    total_cnt++;
    if (beat_cnt4[47:32] !== 16'd1) $display("FAIL route_cnt: got %0d expected %0d", beat_cnt4[47:32], 1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (m_valid4 !== 4'b0000) $display("FAIL route_handoff_clear: got %b expected %b", m_valid4, 4'b0000);
    else pass_cnt++;
    total_cnt++;
    if (m_data4[23:16] !== 8'hA5) $display("FAIL route_data_hold: got %h expected %h", m_data4[23:16], 8'hA5);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    m_ready4 = 4'b1101;
    s_valid4 = 1'b1;
    s_sel4   = 2'd1;
    s_data4  = 8'h11;
    #1;
    total_cnt++;
    if (s_ready4 !== 1'b1) $display("FAIL bp_first_ready: got %b expected %b", s_ready4, 1'b1);
    else pass_cnt++;
    tick();
    s_data4 = 8'h22;
    #1;
    total_cnt++;
    if (s_ready4 !== 1'b0) $display("FAIL bp_second_ready: got %b expected %b", s_ready4, 1'b0);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (m_data4[15:8] !== 8'h11) $display("FAIL bp_held_data: got %h expected %h", m_data4[15:8], 8'h11);
    else pass_cnt++;
    total_cnt++;
    if (m_valid4 !== 4'b0010) $display("FAIL bp_held_valid: got %b expected %b", m_valid4, 4'b0010);
    else pass_cnt++;
    // stalled channel 1 must not block a beat to channel 3
    s_sel4  = 2'd3;
    s_data4 = 8'h33;
    #1;
    total_cnt++;
    if (s_ready4 !== 1'b1) $display("FAIL bp_other_ready: got %b expected %b", s_ready4, 1'b1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (m_valid4 !== 4'b1010) $display("FAIL bp_other_valid: got %b expected %b", m_valid4, 4'b1010);
    else pass_cnt++;
    s_sel4   = 2'd1;
    s_data4  = 8'h22;
    m_ready4 = 4'b1111;
    #1;
    total_cnt++;
    if (s_ready4 !== 1'b1) $display("FAIL bp_release_ready: got %b expected %b", s_ready4, 1'b1);
    else pass_cnt++;
    tick();
    s_valid4 = 1'b0;
    #1;
    total_cnt++;
    if (m_valid4 !== 4'b0010) $display("FAIL bp_passthru_valid: got %b expected %b", m_valid4, 4'b0010);
    else pass_cnt++;
    total_cnt++;
    if (m_data4[15:8] !== 8'h22) $display("FAIL bp_passthru_data: got %h expected %h", m_data4[15:8], 8'h22);
    else pass_cnt++;
    total_cnt++;
    if (beat_cnt4[31:16] !== 16'd2) $display("FAIL bp_cnt: got %0d expected %0d", beat_cnt4[31:16], 2);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (m_valid4 !== 4'b0000) $display("FAIL bp_drain_valid: got %b expected %b", m_valid4, 4'b0000);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    m_ready3 = 3'b111;
    s_valid3 = 1'b1;
    s_sel3   = 2'd3;
    s_data3  = 8'h5A;
    #1;
    total_cnt++;
    if (s_ready3 !== 1'b1) $display("FAIL oor_ready: got %b expected %b", s_ready3, 1'b1);
    else pass_cnt++;
    tick();
    s_valid3 = 1'b0;
    #1;
    total_cnt++;
    if (err3 !== 1'b1) $display("FAIL oor_err_set: got %b expected %b", err3, 1'b1);
    else pass_cnt++;
    total_cnt++;
    if (m_valid3 !== 3'b000) $display("FAIL oor_m_valid: got %b expected %b", m_valid3, 3'b000);
    else pass_cnt++;
    total_cnt++;
    if (beat_cnt3 !== 48'h0) $display("FAIL oor_cnt: got %h expected %h", beat_cnt3, 48'h0);
    else pass_cnt++;
    total_cnt++;
    if (m_data3 !== 24'h0) $display("FAIL oor_m_data: got %h expected %h", m_data3, 24'h0);
    else pass_cnt++;
    err_clr3 = 1'b1;
    tick();
    err_clr3 = 1'b0;
    #1;
    total_cnt++;
    if (err3 !== 1'b0) $display("FAIL oor_err_clr: got %b expected %b", err3, 1'b0);
    else pass_cnt++;
    err_clr3 = 1'b1;
    s_valid3 = 1'b1;
    tick();
    err_clr3 = 1'b0;
    s_valid3 = 1'b0;
    #1;
    total_cnt++;
    if (err3 !== 1'b1) $display("FAIL oor_set_wins: got %b expected %b", err3, 1'b1);
    else pass_cnt++;
    err_clr3 = 1'b1;
    tick();
    err_clr3 = 1'b0;
  endtask

  task automatic test_saturation();
    m_ready4 = 4'b1111;
    s_valid4 = 1'b1;
    s_sel4   = 2'd0;
    s_data4  = 8'h7E;
    repeat (65534) @(posedge clk);
    #1;
    total_cnt++;
    if (beat_cnt4[15:0] !== 16'hFFFE) $display("FAIL sat_near: got %h expected %h", beat_cnt4[15:0], 16'hFFFE);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    s_valid4 = 1'b0;
    total_cnt++;
    if (beat_cnt4[15:0] !== 16'hFFFF) $display("FAIL sat_final: got %h expected %h", beat_cnt4[15:0], 16'hFFFF);
    else pass_cnt++;
    total_cnt++;
    if (beat_cnt4[63:16] !== {16'd1, 16'd1, 16'd2})
      $display("FAIL sat_others: got %h expected %h", beat_cnt4[63:16], {16'd1, 16'd1, 16'd2});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_midtransfer();
    m_ready4 = 4'b0000;
    s_valid4 = 1'b1;
    s_sel4   = 2'd2;
    s_data4  = 8'hA0;
    tick();
    s_valid4 = 1'b0;
    #1;
    total_cnt++;
    if (m_valid4 !== 4'b0100) $display("FAIL mid_held: got %b expected %b", m_valid4, 4'b0100);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (m_valid4 !== 4'b0000) $display("FAIL mid_async_valid: got %b expected %b", m_valid4, 4'b0000);
    else pass_cnt++;
    total_cnt++;
    if (beat_cnt4 !== 64'h0) $display("FAIL mid_async_cnt: got %h expected %h", beat_cnt4, 64'h0);
    else pass_cnt++;
    tick();
    rst_n    = 1'b1;
    m_ready4 = 4'b1111;
    s_valid4 = 1'b1;
    s_data4  = 8'h3C;
    tick();
    s_valid4 = 1'b0;
    #1;
    total_cnt++;
    if (m_valid4 !== 4'b0100) $display("FAIL mid_first_valid: got %b expected %b", m_valid4, 4'b0100);
    else pass_cnt++;
    total_cnt++;
    if (m_data4[23:16] !== 8'h3C) $display("FAIL mid_first_data: got %h expected %h", m_data4[23:16], 8'h3C);
    else pass_cnt++;
    total_cnt++;
    if (beat_cnt4[47:32] !== 16'd1) $display("FAIL mid_first_cnt: got %0d expected %0d", beat_cnt4[47:32], 1);
    else pass_cnt++;
    tick();
  endtask

`ifdef STREAM_DEMUX_RR_EN
  task automatic test_rr();
    logic [3:0] exp_onehot [6];
    exp_onehot[0] = 4'b0001;
    exp_onehot[1] = 4'b0010;
    exp_onehot[2] = 4'b0100;
    exp_onehot[3] = 4'b1000;
    exp_onehot[4] = 4'b0001;
    exp_onehot[5] = 4'b0010;
    do_reset();
    rr_mode4 = 1'b1;
    m_ready4 = 4'b1111;
    s_sel4   = 2'd3;
    s_valid4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data4 = 8'h60 + 8'(i);
      tick();
      total_cnt++;
      if (m_valid4 !== exp_onehot[i])
        $display("FAIL rr_order[%0d]: got %b expected %b", i, m_valid4, exp_onehot[i]);
      else pass_cnt++;
    end
    s_valid4 = 1'b0;
    #1;
    total_cnt++;
    if (m_data4[15:8] !== 8'h65) $display("FAIL rr_data: got %h expected %h", m_data4[15:8], 8'h65);
    else pass_cnt++;
    total_cnt++;
    if (err4 !== 1'b0) $display("FAIL rr_no_err: got %b expected %b", err4, 1'b0);
    else pass_cnt++;
    do_reset();
    s_valid4 = 1'b1;
    s_data4  = 8'h77;
    tick();
    s_valid4 = 1'b0;
    #1;
    total_cnt++;
    if (m_valid4 !== 4'b0001) $display("FAIL rr_after_reset: got %b expected %b", m_valid4, 4'b0001);
    else pass_cnt++;
    rr_mode4 = 1'b0;
    tick();
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    s_valid4 = 1'b0; s_data4 = '0; s_sel4 = '0; m_ready4 = '0; err_clr4 = 1'b0;
    s_valid3 = 1'b0; s_data3 = '0; s_sel3 = '0; m_ready3 = '0; err_clr3 = 1'b0;
`ifdef STREAM_DEMUX_RR_EN
    rr_mode4 = 1'b0;
    rr_mode3 = 1'b0;
`endif
    test_reset();
    test_routing();
    test_backpressure();
    test_out_of_range();
    test_saturation();
    test_reset_midtransfer();
`ifdef STREAM_DEMUX_RR_EN
    test_rr();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
